hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised Tuse/Tnew hazard unit for the 5-stage (F/D/E/M/W) MIPS pipeline.
//  Replaces opcode-matching stall/forward logic: D-stage decoder supplies source/dest
//  regs with Tuse/Tnew; the unit keeps its own E/M/W scoreboard shadowing the pipeline
//  registers, drives stall and all forward selects, and tracks a multi-cycle mult/div unit.
// PARAMETERS
//  REG_AW      5   register-address width (reg 0 never written/forwarded)
//  TNEW_W      2   width of Tuse/Tnew fields, values 0..2^TNEW_W-1
//  MD_MUL_CYC  5   busy cycles loaded for mult/multu
//  MD_DIV_CYC  10  busy cycles loaded for div/divu
// PORTS
//  clk          in   1       pipeline clock
//  reset_n      in   1       asynchronous reset, active low
//  rs_d,rt_d    in   REG_AW  D-stage source regs
//  use_rs_d     in   1       D instr reads rs   (use_rt_d likewise)
//  tuse_rs_d    in   TNEW_W  cycles until rs needed (0=needed in D) (tuse_rt_d likewise)
//  dst_d        in   REG_AW  D-stage dest reg (0 = no write)
//  tnew_d       in   TNEW_W  cycles after entering E until result exists at a stage output
//  md_start_d   in   1       D instr starts mult/div; md_div_d in 1: 1=div, 0=mult
//  md_use_d     in   1       D instr needs MDU idle (mfhi/mflo/mthi/mtlo/mult/div)
//  stall        out  1       freeze PC & F/D, bubble into D/E
//  fwd_rs_d     out  2       D rs select: 0=RF,1=E,2=M,3=W (fwd_rt_d likewise)
//  fwd_rs_e     out  2       E rs select: 0=pipe reg,1=M,2=W (fwd_rt_e likewise)
//  fwd_rt_m     out  1       M store-data select: 0=pipe reg,1=W
//  md_busy      out  1       MDU busy counter non-zero
// BEHAVIOUR
//  - Scoreboard: entries E,M,W each {dst, tnew, rs, rt, use_rs, use_rt}; reset -> all 0.
//  - Every posedge: W<=M, M<=E with tnew=sat_dec(tnew). E<=D entry if !stall, else bubble
//    (dst=0,use=0); D entry tnew loaded as-is. W tnew forced 0.
//  - Stall (comb): for X in {E,M}: dst_X!=0 & use & src_d==dst_X & tnew_X>tuse;
//    OR'd over rs/rt. W never stalls. Plus md stall (see CONFIGURATION).
//  - D forward: pick youngest of E,M,W with dst==src_d!=0; select it iff its tnew==0,
//    else 0 (older stage values are stale; value will be forwarded later in E/M).
//  - E forward: same rule over M,W using scoreboard rs_E/rt_E; M forward: W vs rt_M.
//  - Forward outputs 0 when use flag clear or src reg 0.
//  - stall depends only on D inputs & state: no comb path from outputs to inputs.
//  - Async reset mid-operation: all entries, counter, outputs to 0 immediately;
//    first post-reset cycle stall=0, all fwd=0, md_busy=0.
//  - Latency: stall/fwd combinational same cycle; scoreboard updates 1 cycle later.
// CONFIGURATION
//  - HAZARD_MDU_EN defined: counter cnt (width clog2(MD_DIV_CYC+1)); when D->E advances
//    with md_start_d, cnt<=md_div_d?MD_DIV_CYC:MD_MUL_CYC; else cnt decrements to 0.
//    md_busy=(cnt!=0). stall also asserted when md_use_d & (md_busy | E holds md_start).
//    Start while busy impossible (md_start implies md_use -> stalled).
//  - Not defined: no counter, md_busy tied 0, md_* inputs ignored, no md stall.
// TESTING
//  1 lw $8 (tnew 2) then addu rs=$8 (tuse 1): stall=1 one cycle, then fwd_rs_e=2 (W).
//  2 addu $9 (tnew 1) then beq rs=$9 (tuse 0): stall 1 cycle, next cycle fwd_rs_d=2 (M).
//  3 jal (dst 31,tnew 0) then jr $31: no stall, fwd_rs_d=1 (E); next instr sees 2.
//  4 ori $5 in M & addu $5 in E, D reads $5: fwd_rs_d=1 (E entry) not 2; dst 0 -> fwd 0.
//  5 MDU_EN: div then mflo: stall for 1+MD_DIV_CYC=11 cycles; mult -> 6; md_busy
//    falls exactly when cnt hits 0. Without macro: no stall, md_busy=0.
//  6 reset_n low mid-stall (cnt=4): stall,md_busy,fwd all 0 at once; resume clean.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tuse/Tnew hazard unit for the 5-stage F/D/E/M/W pipeline. It keeps a private
// E/M/W scoreboard that shadows the pipeline registers. From the D-stage
// decoder outputs it drives the stall signal and every forwarding select.
// Optional feature macro: HAZARD_MDU_EN. When defined, the unit tracks the
// busy window of a multi-cycle mult/div unit and stalls instructions that
// need the MDU idle. When undefined, md_busy is tied low and md_* inputs are
// ignored.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int TNEW_W     = 2,
    parameter int MD_MUL_CYC = 5,
    parameter int MD_DIV_CYC = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic [TNEW_W-1:0] tuse_rs_d,
    input  logic [TNEW_W-1:0] tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [TNEW_W-1:0] tnew_d,
    input  logic              md_start_d,
    input  logic              md_div_d,
    input  logic              md_use_d,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [TNEW_W-1:0] tnew;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } entry_t;

    entry_t d_entry;
    entry_t e_entry;
    entry_t m_entry;
    entry_t w_entry;
    logic   md_stall;
    logic   data_stall;

    // Saturating decrement: a result that already exists stays at tnew 0.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // A source must wait when its producer still needs more cycles than the
    // consumer can afford to wait.
    function automatic logic raw_stall(
        input logic [REG_AW-1:0] src,
        input logic              use_src,
        input logic [TNEW_W-1:0] tuse,
        input entry_t            x
    );
        return use_src && (x.dst != '0) && (src == x.dst) && (x.tnew > tuse);
    endfunction

    // D-stage select: the youngest matching stage wins. A match that is not yet
    // ready yields 0, because older stages hold a stale copy of the register.
    function automatic logic [1:0] fwd_d_sel(
        input logic [REG_AW-1:0] src,
        input logic              use_src,
        input entry_t            e,
        input entry_t            m,
        input entry_t            w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src && (src != '0)) begin
            if (e.dst == src)
                sel = (e.tnew == '0) ? 2'd1 : 2'd0;
            else if (m.dst == src)
                sel = (m.tnew == '0) ? 2'd2 : 2'd0;
            else if (w.dst == src)
                sel = 2'd3;
        end
        return sel;
    endfunction

    // E-stage select over the M and W producers, with the same youngest-wins rule.
    function automatic logic [1:0] fwd_e_sel(
        input logic [REG_AW-1:0] src,
        input logic              use_src,
        input entry_t            m,
        input entry_t            w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src && (src != '0)) begin
            if (m.dst == src)
                sel = (m.tnew == '0) ? 2'd1 : 2'd0;
            else if (w.dst == src)
                sel = 2'd2;
        end
        return sel;
    endfunction

    assign d_entry = '{dst: dst_d, tnew: tnew_d, rs: rs_d, rt: rt_d,
                       use_rs: use_rs_d, use_rt: use_rt_d};

    // Advance the scoreboard in lockstep with the pipeline; a stall injects a bubble into E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_entry <= '0;
            m_entry <= '0;
            w_entry <= '0;
        end else begin
            w_entry      <= m_entry;
            w_entry.tnew <= '0;
            m_entry      <= e_entry;
            m_entry.tnew <= sat_dec(e_entry.tnew);
            if (stall)
                e_entry <= '0;
            else
                e_entry <= d_entry;
        end
    end

    // Data-hazard stall: only the E and M stages can still be producing a value.
    always_comb begin
        data_stall = raw_stall(rs_d, use_rs_d, tuse_rs_d, e_entry)
                   | raw_stall(rt_d, use_rt_d, tuse_rt_d, e_entry)
                   | raw_stall(rs_d, use_rs_d, tuse_rs_d, m_entry)
                   | raw_stall(rt_d, use_rt_d, tuse_rt_d, m_entry);
        stall = data_stall | md_stall;
    end

    // Forwarding selects for the D, E and M consumers.
    always_comb begin
        fwd_rs_d = fwd_d_sel(rs_d, use_rs_d, e_entry, m_entry, w_entry);
        fwd_rt_d = fwd_d_sel(rt_d, use_rt_d, e_entry, m_entry, w_entry);
        fwd_rs_e = fwd_e_sel(e_entry.rs, e_entry.use_rs, m_entry, w_entry);
        fwd_rt_e = fwd_e_sel(e_entry.rt, e_entry.use_rt, m_entry, w_entry);
        fwd_rt_m = m_entry.use_rt && (m_entry.rt != '0) && (w_entry.dst == m_entry.rt);
    end

    // The M source fields and the W use/source fields feed no consumer.
    logic unused_entry_bits;
    assign unused_entry_bits = ^{m_entry.rs, m_entry.use_rs, w_entry.rs, w_entry.rt,
                                 w_entry.use_rs, w_entry.use_rt, w_entry.tnew};

`ifdef HAZARD_MDU_EN
    localparam int CNT_W = $clog2(MD_DIV_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             e_md_start;
    logic             e_md_div;

    // Remember whether the instruction now in E launched a mult/div.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else begin
            e_md_start <= !stall && md_start_d;
            e_md_div   <= !stall && md_div_d;
        end
    end

    // Busy counter loads as the mult/div leaves E, then counts down to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (e_md_start)
            cnt <= e_md_div ? CNT_W'(MD_DIV_CYC) : CNT_W'(MD_MUL_CYC);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign md_busy  = (cnt != '0);
    assign md_stall = md_use_d && (md_busy || e_md_start);
`else
    localparam int unused_md_cyc = MD_MUL_CYC + MD_DIV_CYC;

    logic unused_md_inputs;
    assign unused_md_inputs = ^{md_start_d, md_div_d, md_use_d};
    assign md_busy          = 1'b0;
    assign md_stall         = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed vectors for hazard_scoreboard with hand-computed expectations.
// Compile with +define+HAZARD_MDU_EN to exercise the mult/div tracking.
module tb_hazard_scoreboard;

    localparam int MD_MUL_CYC = 5;
    localparam int MD_DIV_CYC = 10;
`ifdef HAZARD_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [4:0] rs_d, rt_d, dst_d;
    logic       use_rs_d, use_rt_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       md_start_d, md_div_d, md_use_d;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;
    logic       md_busy;

    int vector_count = 0;
    int miss_count   = 0;
    int stall_cycles;
    int busy_cycles;

    hazard_scoreboard #(
        .REG_AW(5), .TNEW_W(2), .MD_MUL_CYC(MD_MUL_CYC), .MD_DIV_CYC(MD_DIV_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .dst_d(dst_d), .tnew_d(tnew_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
        .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                                 input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                                 input logic [4:0] dst, input logic [1:0] tnew,
                                 input logic mds, input logic mdd, input logic mdu);
        rs_d = rs; use_rs_d = urs; tuse_rs_d = trs;
        rt_d = rt; use_rt_d = urt; tuse_rt_d = trt;
        dst_d = dst; tnew_d = tnew;
        md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    // Stall on mflo after a mult/div, counting stalled and busy cycles.
    task automatic mduRun(input logic is_div, input string tag, input int exp_stall,
                          input int exp_busy);
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, is_div, 1);
        checkOutput({tag, "_issue_stall"}, stall, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd2, 2'd0, 0, 0, 1);
        stall_cycles = 0;
        busy_cycles  = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            stall_cycles++;
            if (md_busy) busy_cycles++;
            tick();
        end
        checkOutput({tag, "_stall_cycles"}, stall_cycles, exp_stall);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        checkOutput({tag, "_busy_after"}, md_busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_fwd_rs_d", fwd_rs_d, 0);
        checkOutput("reset_md_busy", md_busy, 0);
        #12 reset_n = 1'b1;
        tick();

        // lw $8 then addu reading $8 with tuse 1
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd8, 2'd2, 0, 0, 0);
        checkOutput("t1_lw_stall", stall, 0);
        tick();
        applyStimulus(5'd8, 1, 2'd1, 0, 0, 0, 5'd10, 2'd1, 0, 0, 0);
        checkOutput("t1_stall", stall, 1);
        tick();
        checkOutput("t1_nostall_eq", stall, 0);
        checkOutput("t1_fwd_rs_d_stale", fwd_rs_d, 0);
        tick();
        idle();
        checkOutput("t1_fwd_rs_e", fwd_rs_e, 2);

        // addu $9 then beq reading $9 with tuse 0
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 2'd1, 0, 0, 0);
        tick();
        applyStimulus(5'd9, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_stall", stall, 1);
        checkOutput("t2_fwd_rs_d_wait", fwd_rs_d, 0);
        tick();
        checkOutput("t2_nostall", stall, 0);
        checkOutput("t2_fwd_rs_d", fwd_rs_d, 2);

        // jal then jr $31, then further readers of $31
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd31, 2'd0, 0, 0, 0);
        tick();
        applyStimulus(5'd31, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_stall", stall, 0);
        checkOutput("t3_fwd_rs_d_e", fwd_rs_d, 1);
        tick();
        checkOutput("t3_fwd_rs_d_m", fwd_rs_d, 2);
        checkOutput("t3_fwd_rs_e_m", fwd_rs_e, 1);
        tick();
        checkOutput("t3_fwd_rs_d_w", fwd_rs_d, 3);
        checkOutput("t3_fwd_rs_e_w", fwd_rs_e, 2);

        // ori $5 in M and addu $5 in E: youngest producer wins
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 2'd0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 2'd0, 0, 0, 0);
        tick();
        applyStimulus(5'd5, 1, 2'd0, 5'd0, 1, 2'd0, 0, 0, 0, 0, 0);
        checkOutput("t4_fwd_rs_d_young", fwd_rs_d, 1);
        checkOutput("t4_fwd_rt_d_zero", fwd_rt_d, 0);
        checkOutput("t4_stall", stall, 0);
        applyStimulus(5'd5, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_fwd_nouse", fwd_rs_d, 0);
        applyStimulus(5'd5, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        checkOutput("t4_fwd_rs_e", fwd_rs_e, 1);

        // lw $6 then sw storing $6: data forwarded from W into M
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd6, 2'd2, 0, 0, 0);
        tick();
        applyStimulus(5'd0, 1, 2'd1, 5'd6, 1, 2'd2, 0, 0, 0, 0, 0);
        checkOutput("t4s_stall", stall, 0);
        checkOutput("t4s_fwd_rt_d", fwd_rt_d, 0);
        tick();
        idle();
        checkOutput("t4s_fwd_rt_e", fwd_rt_e, 0);
        tick();
        checkOutput("t4s_fwd_rt_m", fwd_rt_m, 1);
        tick();
        checkOutput("t4s_fwd_rt_m_gone", fwd_rt_m, 0);

        // mult/div followed by mflo
        mduRun(1'b1, "t5_div", MDU_ON ? 1 + MD_DIV_CYC : 0, MDU_ON ? MD_DIV_CYC : 0);
        mduRun(1'b0, "t5_mult", MDU_ON ? 1 + MD_MUL_CYC : 0, MDU_ON ? MD_MUL_CYC : 0);

        // reset asserted in the middle of a stall
        flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd8, 2'd2, 1, 1, 1);
        tick();
        applyStimulus(5'd8, 1, 2'd1, 0, 0, 0, 5'd10, 2'd1, 0, 0, 1);
        checkOutput("t6_stall_before", stall, 1);
        if (MDU_ON) begin
            repeat (7) tick();
            checkOutput("t6_busy_before", md_busy, 1);
            checkOutput("t6_stall_busy", stall, 1);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("t6_reset_stall", stall, 0);
        checkOutput("t6_reset_busy", md_busy, 0);
        checkOutput("t6_reset_fwd_rs_d", fwd_rs_d, 0);
        checkOutput("t6_reset_fwd_rs_e", fwd_rs_e, 0);
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("t6_resume_stall", stall, 0);
        checkOutput("t6_resume_busy", md_busy, 0);
        tick();
        checkOutput("t6_resume_stall2", stall, 0);
        checkOutput("t6_resume_busy2", md_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
